// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage between EX and writeback.
// Accepts one EX result at a time. Non-memory ops write back on the next
// cycle. Memory ops issue one data-bus request, wait for the response,
// then write back. Store strobes/data and load extraction are lane-shifted
// by the low three address bits.
// Optional feature macro: MEM_MISALIGN_CHECK_EN. When defined, accesses
// that are not naturally aligned are refused with a misalign writeback.
// When undefined, bytes past the 8-byte boundary are silently dropped.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  output logic        ls_ready_o,
  input  logic [63:0] mem_addr_i,
  input  logic [63:0] mem_wdata_i,
  input  logic [10:0] ls_info_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        rd_wen_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [63:0] rd_data_i,
  output logic        dbus_req_valid_o,
  input  logic        dbus_req_ready_i,
  output logic [63:0] dbus_addr_o,
  output logic        dbus_wen_o,
  output logic [63:0] dbus_wdata_o,
  output logic [7:0]  dbus_wstrb_o,
  input  logic        dbus_resp_valid_i,
  input  logic [63:0] dbus_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_rd_wen_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [63:0] wb_rd_data_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  // Everything captured from EX at acceptance.
  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [10:0] info;
    logic        is_load;   // read wins when both enables are set
    logic        is_store;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
  } op_t;

  state_t      r_state, w_state_nxt;
  op_t         r_op;
  logic        r_wb_valid, r_wb_rd_wen;
  logic [4:0]  r_wb_rd_addr;
  logic [63:0] r_wb_rd_data;

  logic        w_acc, w_mem, w_mis, w_wb_fire;
  logic [2:0]  w_a;
  logic [63:0] w_sh, w_ld;
  logic [7:0]  w_strb;

  assign ls_ready_o = (r_state == S_IDLE);
  assign w_acc      = ex_valid_i & ls_ready_o;
  assign w_mem      = mem_read_i | mem_write_i;
  assign w_a        = r_op.addr[2:0];

`ifdef MEM_MISALIGN_CHECK_EN
  logic w_half, w_word, w_dbl, r_misalign;
  assign w_half = ls_info_i[9] | ls_info_i[5] | ls_info_i[2];
  assign w_word = ls_info_i[8] | ls_info_i[4] | ls_info_i[1];
  assign w_dbl  = ls_info_i[7] | ls_info_i[0];
  assign w_mis  = (w_half & mem_addr_i[0]) | (w_word & (|mem_addr_i[1:0]))
                | (w_dbl & (|mem_addr_i[2:0]));

  // Misalign flag pulses on the cycle after a refused access.
  always_ff @(posedge clk) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= w_acc & w_mem & w_mis;
  end
  assign misalign_o = r_misalign;
`else
  assign w_mis      = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and writeback trigger.
  always_comb begin
    w_state_nxt = r_state;
    w_wb_fire   = 1'b0;
    case (r_state)
      S_IDLE: if (w_acc) begin
        if (w_mem && !w_mis) w_state_nxt = S_REQ;
        else                 w_wb_fire   = 1'b1;
      end
      S_REQ:  if (dbus_req_ready_i) w_state_nxt = S_RESP;
      S_RESP: if (dbus_resp_valid_i) begin
        w_state_nxt = S_IDLE;
        w_wb_fire   = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the EX op on acceptance; held stable for the whole bus transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op <= '0;
    end else if (w_acc) begin
      r_op.addr     <= mem_addr_i;
      r_op.wdata    <= mem_wdata_i;
      r_op.info     <= ls_info_i;
      r_op.is_load  <= mem_read_i;
      r_op.is_store <= mem_write_i & ~mem_read_i;
      r_op.rd_wen   <= rd_wen_i;
      r_op.rd_addr  <= rd_addr_i;
      r_op.rd_data  <= rd_data_i;
    end
  end

  // Request side: aligned address, lane-shifted data and byte strobes.
  always_comb begin
    w_strb = 8'h00;
    if (r_op.is_store) begin
      if      (r_op.info[3]) w_strb = 8'h01 << w_a;
      else if (r_op.info[2]) w_strb = 8'h03 << w_a;
      else if (r_op.info[1]) w_strb = 8'h0F << w_a;
      else if (r_op.info[0]) w_strb = 8'hFF;
    end
  end

  assign dbus_req_valid_o = (r_state == S_REQ);
  assign dbus_addr_o      = {r_op.addr[63:3], 3'b000};
  assign dbus_wen_o       = r_op.is_store;
  assign dbus_wdata_o     = r_op.wdata << {w_a, 3'b000};
  assign dbus_wstrb_o     = w_strb;

  // Load extraction: shift the addressed byte to lane 0, then size/extend.
  always_comb begin
    w_sh = dbus_rdata_i >> {w_a, 3'b000};
    w_ld = 64'h0;
    if      (r_op.info[10]) w_ld = {{56{w_sh[7]}},  w_sh[7:0]};
    else if (r_op.info[9])  w_ld = {{48{w_sh[15]}}, w_sh[15:0]};
    else if (r_op.info[8])  w_ld = {{32{w_sh[31]}}, w_sh[31:0]};
    else if (r_op.info[7])  w_ld = w_sh;
    else if (r_op.info[6])  w_ld = {56'h0, w_sh[7:0]};
    else if (r_op.info[5])  w_ld = {48'h0, w_sh[15:0]};
    else if (r_op.info[4])  w_ld = {32'h0, w_sh[31:0]};
  end

  // Writeback register: one-cycle valid pulse, fields held between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wb_valid   <= 1'b0;
      r_wb_rd_wen  <= 1'b0;
      r_wb_rd_addr <= 5'h0;
      r_wb_rd_data <= 64'h0;
    end else begin
      r_wb_valid <= w_wb_fire;
      if (w_wb_fire) begin
        if (r_state == S_IDLE) begin
          // Non-memory op, or refused misaligned access.
          r_wb_rd_wen  <= w_mem ? 1'b0 : rd_wen_i;
          r_wb_rd_addr <= rd_addr_i;
          r_wb_rd_data <= rd_data_i;
        end else begin
          r_wb_rd_wen  <= r_op.is_load & r_op.rd_wen;
          r_wb_rd_addr <= r_op.rd_addr;
          r_wb_rd_data <= r_op.is_load ? w_ld : r_op.rd_data;
        end
      end
    end
  end

  assign wb_valid_o   = r_wb_valid;
  assign wb_rd_wen_o  = r_wb_rd_wen;
  assign wb_rd_addr_o = r_wb_rd_addr;
  assign wb_rd_data_o = r_wb_rd_data;

endmodule
